// File: rtl/syscall_unit_if.sv
// Memory read port and console byte stream shared by syscall_unit and its environment.
interface syscall_unit_if;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_ready;

    // Unit side: issues reads, drives console bytes.
    modport master (
        output mem_rd, mem_addr, out_valid, out_data,
        input  mem_rdata, mem_ack, out_ready
    );

    // Environment side: memory responder and console sink.
    modport slave (
        input  mem_rd, mem_addr, out_valid, out_data,
        output mem_rdata, mem_ack, out_ready
    );
endinterface

// File: rtl/syscall_unit.sv
// Syscall service unit: samples $v0/$a0 when decode flags a syscall, stalls the
// pipeline and streams console bytes for print_int, print_string and print_char.
// exit parks the unit in a sticky halted state until reset.
module syscall_unit #(
    parameter int MAX_STR = 256
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           sys_en,
    input  logic [31:0]    v0,
    input  logic [31:0]    a0,
    output logic           stall,
    output logic           halted,
    output logic           err,
    syscall_unit_if.master bus
);
    localparam int CNT_W = $clog2(MAX_STR + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INT_CONV,
        S_INT_EMIT,
        S_STR_REQ,
        S_STR_EMIT,
        S_CHR_EMIT,
        S_DONE,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      arg_q, arg_d;     // captured a0; doubles as the string pointer
    logic             neg_q, neg_d;     // '-' still owed for print_int
    logic [31:0]      mag_q, mag_d;     // remaining magnitude during conversion
    logic [3:0]       idx_q, idx_d;     // conversion: slot to fill; emit: digit to send
    logic [7:0]       byte_q, byte_d;   // string byte waiting for the console
    logic [CNT_W-1:0] sent_q, sent_d;   // string bytes already delivered
    logic             err_q, err_d;

    logic [39:0]      digits_flat;      // 10 BCD digits, slot 0 is least significant
    logic             digit_we;
    logic [3:0]       digit_wdata;
    logic [3:0]       digit_sel;
    logic [31:0]      mag_div;
    logic [7:0]       sel_byte;

    logic             mem_rd_c;
    logic [31:0]      mem_addr_c;
    logic             out_valid_c;
    logic [7:0]       out_data_c;

    assign mag_div     = mag_q / 32'd10;
    assign digit_wdata = 4'(mag_q % 32'd10);
    assign digit_sel   = digits_flat[{idx_q, 2'b00} +: 4];

    // Pick the addressed byte out of the returned word, little-endian.
    always_comb begin
        sel_byte = bus.mem_rdata[7:0];
        case (arg_q[1:0])
            2'd0: sel_byte = bus.mem_rdata[7:0];
            2'd1: sel_byte = bus.mem_rdata[15:8];
            2'd2: sel_byte = bus.mem_rdata[23:16];
            2'd3: sel_byte = bus.mem_rdata[31:24];
            default: sel_byte = bus.mem_rdata[7:0];
        endcase
    end

    // Digit buffer: each slot loads only while conversion points at it.
    genvar gi;
    generate
        for (gi = 0; gi < 10; gi++) begin : g_digit
            logic [3:0] slot_q;
            // Store the remainder produced this cycle into this slot.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    slot_q <= '0;
                end else if (digit_we && (idx_q == 4'(gi))) begin
                    slot_q <= digit_wdata;
                end
            end
            assign digits_flat[gi*4 +: 4] = slot_q;
        end
    endgenerate

    // Next-state, datapath updates and all handshake outputs.
    always_comb begin
        state_d     = state_q;
        arg_d       = arg_q;
        neg_d       = neg_q;
        mag_d       = mag_q;
        idx_d       = idx_q;
        byte_d      = byte_q;
        sent_d      = sent_q;
        err_d       = 1'b0;
        digit_we    = 1'b0;
        stall       = 1'b0;
        mem_rd_c    = 1'b0;
        mem_addr_c  = '0;
        out_valid_c = 1'b0;
        out_data_c  = '0;

        case (state_q)
            S_IDLE: begin
                if (sys_en) begin
                    // Stall combinationally so the PC holds on this very edge.
                    stall  = 1'b1;
                    arg_d  = a0;
                    neg_d  = a0[31];
                    mag_d  = a0[31] ? (~a0 + 32'd1) : a0;
                    idx_d  = '0;
                    sent_d = '0;
                    case (v0)
                        32'd1:   state_d = S_INT_CONV;
                        32'd4:   state_d = S_STR_REQ;
                        32'd11:  state_d = S_CHR_EMIT;
                        32'd10:  state_d = S_HALT;
                        default: begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end

            S_INT_CONV: begin
                stall    = 1'b1;
                digit_we = 1'b1;
                mag_d    = mag_div;
                // At least one digit is always stored, so zero prints as "0".
                if (mag_div == 32'd0) begin
                    state_d = S_INT_EMIT;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end

            S_INT_EMIT: begin
                stall       = 1'b1;
                out_valid_c = 1'b1;
                out_data_c  = neg_q ? 8'h2D : {4'h3, digit_sel};
                if (bus.out_ready) begin
                    if (neg_q) begin
                        neg_d = 1'b0;
                    end else if (idx_q == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q - 4'd1;
                    end
                end
            end

            S_STR_REQ: begin
                stall      = 1'b1;
                mem_rd_c   = 1'b1;
                mem_addr_c = {arg_q[31:2], 2'b00};
                if (bus.mem_ack) begin
                    // NUL terminates silently; the byte budget truncates long strings.
                    if ((sel_byte == 8'h00) || (sent_q == CNT_W'(MAX_STR))) begin
                        state_d = S_DONE;
                    end else begin
                        byte_d  = sel_byte;
                        state_d = S_STR_EMIT;
                    end
                end
            end

            S_STR_EMIT: begin
                stall       = 1'b1;
                out_valid_c = 1'b1;
                out_data_c  = byte_q;
                if (bus.out_ready) begin
                    arg_d   = arg_q + 32'd1;
                    sent_d  = sent_q + CNT_W'(1);
                    state_d = S_STR_REQ;
                end
            end

            S_CHR_EMIT: begin
                stall       = 1'b1;
                out_valid_c = 1'b1;
                out_data_c  = arg_q[7:0];
                if (bus.out_ready) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                // One unstalled cycle lets the PC step past the syscall.
                state_d = S_IDLE;
            end

            S_HALT: begin
                stall = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            arg_q   <= '0;
            neg_q   <= 1'b0;
            mag_q   <= '0;
            idx_q   <= '0;
            byte_q  <= '0;
            sent_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            arg_q   <= arg_d;
            neg_q   <= neg_d;
            mag_q   <= mag_d;
            idx_q   <= idx_d;
            byte_q  <= byte_d;
            sent_q  <= sent_d;
            err_q   <= err_d;
        end
    end

    assign halted        = (state_q == S_HALT);
    assign err           = err_q;
    assign bus.mem_rd    = mem_rd_c;
    assign bus.mem_addr  = mem_addr_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_c;
endmodule

// File: tb/tb_syscall_unit.sv
// Randomized self-checking bench for syscall_unit: a byte-stream reference
// model, a memory responder with variable latency and a console sink with
// random back-pressure.
module tb_syscall_unit;
    localparam int MAX_STR = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sys_en = 1'b0;
    logic [31:0] v0 = '0;
    logic [31:0] a0 = '0;
    logic        stall;
    logic        halted;
    logic        err;

    syscall_unit_if bus ();

    syscall_unit #(.MAX_STR(MAX_STR)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sys_en (sys_en),
        .v0     (v0),
        .a0     (a0),
        .stall  (stall),
        .halted (halted),
        .err    (err),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  exp_q[$];
    logic [31:0] addr_q[$];
    string       got_s = "";
    int          err_cycles = 0;
    int          stall_cycles = 0;
    int          ready_pct = 100;
    int          ack_delay = 0;     // <0 selects a random 0..3 cycle latency
    logic [7:0]  mem_b [1024];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_str(input string name, input string act, input string req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, req);
        end
    endtask

    function automatic logic [7:0] mb(input logic [31:0] a);
        return mem_b[a[9:0]];
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return {mb(w + 32'd3), mb(w + 32'd2), mb(w + 32'd1), mb(w)};
    endfunction

    // Reference model: the console bytes and word reads a syscall must produce.
    task automatic build_expect(input logic [31:0] code, input logic [31:0] arg,
                                output int exp_err, output bit exp_halt);
        string       s;
        logic [31:0] p;
        exp_err  = 0;
        exp_halt = 1'b0;
        case (code)
            32'd1: begin
                s = $sformatf("%0d", $signed(arg));
                for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
            end
            32'd4: begin
                for (int i = 0; i <= MAX_STR; i++) begin
                    p = arg + 32'(i);
                    addr_q.push_back({p[31:2], 2'b00});
                    if (mb(p) == 8'h00 || i == MAX_STR) break;
                    exp_q.push_back(mb(p));
                end
            end
            32'd11: exp_q.push_back(arg[7:0]);
            32'd10: exp_halt = 1'b1;
            default: exp_err = 1;
        endcase
    endtask

    // Console sink back-pressure.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            bus.out_ready = ($urandom_range(99, 0) < ready_pct);
        end
    end

    // Memory responder: checks each requested address, answers after a latency.
    initial begin
        bit          pend;
        int          dly;
        logic [31:0] pend_addr;
        pend = 1'b0;
        dly = 0;
        pend_addr = '0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            bus.mem_rdata = $urandom;
            if (!rst_n) begin
                pend = 1'b0;
            end else if (pend) begin
                if (dly == 0) begin
                    bus.mem_ack = 1'b1;
                    bus.mem_rdata = word_at(pend_addr);
                    pend = 1'b0;
                end else begin
                    dly--;
                end
            end else if (bus.mem_rd) begin
                if (addr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL mem_read: unexpected read at 0x%0h", bus.mem_addr);
                end else begin
                    check("mem_addr", bus.mem_addr, addr_q.pop_front());
                end
                pend_addr = bus.mem_addr;
                pend = 1'b1;
                dly = (ack_delay < 0) ? int'($urandom_range(3, 0)) : ack_delay;
            end
        end
    end

    // Compare process: every transfer against the model, plus output stability.
    initial begin
        bit         prev_hold;
        logic [7:0] prev_data;
        prev_hold = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_hold = 1'b0;
            end else begin
                if (err) err_cycles++;
                if (stall) stall_cycles++;
                if (prev_hold) begin
                    check("out_hold_valid", 32'(bus.out_valid), 32'd1);
                    check("out_hold_data", 32'(bus.out_data), 32'(prev_data));
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL out_byte: unexpected byte 0x%0h", bus.out_data);
                    end else begin
                        check("out_byte", 32'(bus.out_data), 32'(exp_q.pop_front()));
                    end
                    got_s = $sformatf("%s%c", got_s, bus.out_data);
                end
                prev_hold = bus.out_valid && !bus.out_ready;
                prev_data = bus.out_data;
            end
        end
    end

    // One full syscall: issue, wait for the DONE cycle, audit the window.
    task automatic do_syscall(input logic [31:0] code, input logic [31:0] arg,
                              input int dly, input int rpct);
        int exp_err;
        bit exp_halt;
        int n;
        ack_delay = dly;
        ready_pct = rpct;
        build_expect(code, arg, exp_err, exp_halt);
        @(posedge clk); #1;
        v0 = code;
        a0 = arg;
        sys_en = 1'b1;
        err_cycles = 0;
        stall_cycles = 0;
        @(negedge clk);
        check("stall_on_sys_en", 32'(stall), 32'd1);
        @(posedge clk); #1;
        sys_en = 1'b0;
        v0 = $urandom;
        a0 = $urandom;
        if (exp_halt) begin
            repeat (3) @(negedge clk);
            check("halt_halted", 32'(halted), 32'd1);
            check("halt_stall", 32'(stall), 32'd1);
            return;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (stall && n < 3000);
        #1;
        if (n >= 3000) begin
            tests++;
            fails++;
            $display("FAIL timeout: code %0d still stalled after %0d cycles", code, n);
        end
        $display("[TB] syscall v0=%0d a0=0x%08h cycles=%0d", code, arg, n);
        check("done_bytes_left", 32'(exp_q.size()), 32'd0);
        check("done_reads_left", 32'(addr_q.size()), 32'd0);
        check("done_out_valid", 32'(bus.out_valid), 32'd0);
        check("done_err_cycles", 32'(err_cycles), 32'(exp_err));
        check("done_halted", 32'(halted), 32'd0);
        exp_q.delete();
        addr_q.delete();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_stall"}, 32'(stall), 32'd0);
        check({tag, "_halted"}, 32'(halted), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_mem_rd"}, 32'(bus.mem_rd), 32'd0);
        check({tag, "_mem_addr"}, bus.mem_addr, 32'd0);
        check({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_out_data"}, 32'(bus.out_data), 32'd0);
    endtask

    task automatic apply_reset(input string tag);
        sys_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check_reset_state(tag);
        exp_q.delete();
        addr_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] codes [8];
        logic [31:0] code;
        logic [31:0] arg;
        codes = '{32'd1, 32'd4, 32'd11, 32'd1, 32'd4, 32'd0, 32'd5, 32'd12};

        // Memory: random bytes with scattered NULs, plus fixed strings.
        for (int i = 0; i < 1024; i++)
            mem_b[i] = ($urandom_range(7, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 1));
        mem_b[10'h003] = "H"; mem_b[10'h004] = "i"; mem_b[10'h005] = 8'h00;
        mem_b[10'h3FD] = "a"; mem_b[10'h3FE] = "b"; mem_b[10'h3FF] = "c"; mem_b[10'h000] = 8'h00;
        for (int i = 0; i < 24; i++) mem_b[10'h200 + i] = 8'h61 + 8'(i);

        #1;
        check_reset_state("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // print_char with a ready console.
        got_s = "";
        do_syscall(32'd11, 32'h41, 0, 100);
        check("t1_stall_cycles", 32'(stall_cycles), 32'd2);
        check_str("t1_text", got_s, "A");

        // print_int corners, with and without back-pressure.
        got_s = "";
        do_syscall(32'd1, -32'sd305, 0, 100);
        check_str("t2_neg305", got_s, "-305");
        got_s = "";
        do_syscall(32'd1, 32'd0, 0, 100);
        check_str("t2_zero", got_s, "0");
        got_s = "";
        do_syscall(32'd1, 32'h8000_0000, 0, 40);
        check_str("t2_min", got_s, "-2147483648");
        got_s = "";
        do_syscall(32'd1, 32'h7FFF_FFFF, 0, 40);
        check_str("t2_max", got_s, "2147483647");

        // print_string: unaligned, slow memory; wrap through address 0; truncation.
        got_s = "";
        do_syscall(32'd4, 32'h0000_1003, 3, 100);
        check_str("t3_hi", got_s, "Hi");
        got_s = "";
        do_syscall(32'd4, 32'hFFFF_FFFD, -1, 60);
        check_str("t3_wrap", got_s, "abc");
        got_s = "";
        do_syscall(32'd4, 32'h0000_0200, -1, 60);
        check_str("t3_trunc", got_s, "abcdefghijklmnop");

        // Unsupported code.
        got_s = "";
        do_syscall(32'd7, 32'h1234, 0, 100);
        check_str("t6_no_output", got_s, "");

        // Random mix with random back-pressure and memory latency.
        for (int t = 0; t < 40; t++) begin
            code = codes[$urandom_range(7, 0)];
            case ($urandom_range(3, 0))
                0: arg = $urandom;
                1: arg = 32'($urandom_range(20, 0)) - 32'd10;
                2: arg = 32'($urandom_range(1023, 0));
                default: arg = {$urandom_range(1, 0) == 1 ? 1'b1 : 1'b0, 31'($urandom)};
            endcase
            do_syscall(code, arg, -1, int'($urandom_range(90, 20)));
        end

        // exit: sticky halt, later syscalls ignored, reset clears.
        do_syscall(32'd10, 32'd0, 0, 100);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            v0 = 32'd11;
            a0 = 32'h5A;
            sys_en = 1'b1;
            @(posedge clk); #1;
            sys_en = 1'b0;
            @(negedge clk);
            check("halt_hold_halted", 32'(halted), 32'd1);
            check("halt_hold_stall", 32'(stall), 32'd1);
            check("halt_hold_valid", 32'(bus.out_valid), 32'd0);
        end
        apply_reset("halt_reset");

        // Reset in the middle of a print_string.
        ready_pct = 50;
        ack_delay = 1;
        begin
            int exp_err;
            bit exp_halt;
            build_expect(32'd4, 32'h0000_0200, exp_err, exp_halt);
        end
        @(posedge clk); #1;
        v0 = 32'd4;
        a0 = 32'h0000_0200;
        sys_en = 1'b1;
        @(posedge clk); #1;
        sys_en = 1'b0;
        repeat (9) @(posedge clk);
        apply_reset("mid_reset");

        // Recovery after the mid-string reset.
        got_s = "";
        do_syscall(32'd11, 32'h00, 0, 100);
        check("recover_len", 32'(got_s.len()), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time guard.
    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end
endmodule
